alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Iterative shift-and-add multiplier sequencer that time-shares the 64-bit ALU with the main datapath.
//  Sits between the decode/datapath and the ALU operand/select ports.
//  On a MUL request it takes ownership of the ALU and drives one add per cycle until the product is complete.
//  While it owns the ALU it stalls the datapath; otherwise the datapath operands pass straight through.
// PARAMETERS
//  WIDTH       64       operand/product width (low WIDTH bits of product kept)
//  CNT_W       7        iteration counter width, must hold WIDTH
//  EARLY_EXIT  1        1: stop when remaining multiplier bits are zero; 0: always WIDTH iterations
//  ADD_SEL     4'b0010  ALU select code for A+B (no inversion, arithmetic)
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  dp_a      in   WIDTH  datapath ALU operand A
//  dp_b      in   WIDTH  datapath ALU operand B
//  dp_sel    in   4      datapath ALU select
//  start     in   1      MUL request, sampled only when ready=1
//  mul_a     in   WIDTH  multiplicand, captured on accepted start
//  mul_b     in   WIDTH  multiplier, captured on accepted start
//  alu_f     in   WIDTH  ALU result (combinational, same cycle)
//  alu_a     out  WIDTH  to ALU ain
//  alu_b     out  WIDTH  to ALU bin
//  alu_sel   out  4      to ALU S
//  ready     out  1      1 in IDLE: start will be accepted
//  busy      out  1      1 in RUN: sequencer owns the ALU
//  dp_stall  out  1      equals busy; datapath must hold its state
//  done      out  1      one-cycle pulse, product valid
//  product   out  WIDTH  low WIDTH bits of mul_a*mul_b, held until next accepted start
// BEHAVIOUR
//  - Reset values: state=IDLE, acc/mcand/mplier/count/product=0, done=0, busy=0, ready=1.
//  - FSM IDLE -> RUN on start&ready; RUN -> DONE on final iteration; DONE -> IDLE unconditionally.
//  - Accepted start: mcand<=mul_a, mplier<=mul_b, acc<=0, count<=0.
//  - start while not IDLE (RUN or DONE) is ignored, not queued.
//  - ALU mux: RUN -> alu_a=acc, alu_b=mplier[0]?mcand:0, alu_sel=ADD_SEL.
//    IDLE/DONE -> alu_a=dp_a, alu_b=dp_b, alu_sel=dp_sel (pure combinational pass-through).
//  - Each RUN cycle: acc<=alu_f; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
//  - Final iteration:
//    - EARLY_EXIT=1: (mplier>>1)==0, or count==WIDTH-1.
//    - EARLY_EXIT=0: count==WIDTH-1.
//  - RUN cycle count with EARLY_EXIT=1 is (index of highest set bit of mul_b)+1, minimum 1 (mul_b=0 gives 1 cycle).
//  - On the final RUN edge: product<=alu_f; state<=DONE.
//  - done=1 only in DONE; product stays stable from DONE until the next accepted start.
//  - Arithmetic is modulo 2^WIDTH; ALU carry/overflow ignored; bits shifted out of mcand discarded. Unsigned == signed low half.
//  - busy=dp_stall=(state==RUN); ready=(state==IDLE).
//  - Reset asserted mid-RUN: next edge returns to IDLE with all reset values; the partial product is lost; done not pulsed.
// TESTING
//  - reset 2 cycles -> ready=1, busy=0, done=0, product=0; dp_a=5, dp_b=3, dp_sel=4'b0010 appear on alu_a/b/sel.
//  - start, mul_a=3, mul_b=5 (EARLY_EXIT=1) -> busy for 3 cycles, then done pulse with product=15; ready 1 cycle after done.
//  - mul_a=64'hFFFF_FFFF_FFFF_FFFF, mul_b=2 -> 2 RUN cycles, product=64'hFFFF_FFFF_FFFF_FFFE (wrap).
//  - mul_a=7, mul_b=0 -> exactly 1 RUN cycle, product=0; mul_a=1, mul_b=64'h8000_0000_0000_0000 -> 64 RUN cycles, product=64'h8000_0000_0000_0000.
//  - start held high during RUN/DONE -> no restart until IDLE; during RUN, dp_stall=1 and alu_sel=ADD_SEL regardless of dp_sel.
//  - reset asserted at 10th RUN cycle of 64-cycle op -> next cycle IDLE, busy=0, product=0, no done pulse.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier that borrows the shared ALU, one add per cycle,
// and passes the datapath operands straight through to the ALU while idle.
module alu_mul_sequencer #(
    parameter int          WIDTH      = 64,
    parameter int          CNT_W      = 7,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter logic [3:0]  ADD_SEL    = 4'b0010
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dp_a,
    input  logic [WIDTH-1:0] dp_b,
    input  logic [3:0]       dp_sel,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] alu_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             ready,
    output logic             busy,
    output logic             dp_stall,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;

    // Final iteration: counter exhausted, or (early exit) no multiplier bits left to add.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        mplier_next = mplier >> 1;
        last_iter   = (count == CNT_W'(WIDTH - 1));
        if (EARLY_EXIT && (mplier_next == '0)) begin
            last_iter = 1'b1;
        end
    end

    always_comb begin
        alu_a   = dp_a;
        alu_b   = dp_b;
        alu_sel = dp_sel;
        if (state == RUN) begin
            alu_a   = acc;
            alu_b   = mplier[0] ? mcand : '0;
            alu_sel = ADD_SEL;
        end
    end

    assign dp_stall = busy;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mul_a;
                        mplier <= mul_b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end
                end
                RUN: begin
                    acc    <= alu_f;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        product <= alu_f;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: behavioural ALU, arithmetic product model,
// directed corner cases followed by randomized multiplies.
module tb_alu_mul_sequencer;

    localparam logic [3:0] ADD_SEL = 4'b0010;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] dp_a, dp_b;
    logic [3:0]  dp_sel;
    logic        start;
    logic [63:0] mul_a, mul_b;
    logic [63:0] alu_f;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic        ready, busy, dp_stall, done;
    logic [63:0] product;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Behavioural ALU: add for the add code, XOR for anything else.
    assign alu_f = (alu_sel == ADD_SEL) ? (alu_a + alu_b) : (alu_a ^ alu_b);

    alu_mul_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_sel   (dp_sel),
        .start    (start),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .alu_f    (alu_f),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .ready    (ready),
        .busy     (busy),
        .dp_stall (dp_stall),
        .done     (done),
        .product  (product)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_cycles(input logic [63:0] b);
        int n = 1;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input bit hold_start);
        logic [63:0] exp_p;
        int          exp_n;
        int          n;
        exp_p = a * b;
        exp_n = ref_cycles(b);
        @(negedge clock);
        check("ready_before_start", 64'(ready), 64'd1);
        start  = 1'b1;
        mul_a  = a;
        mul_b  = b;
        dp_sel = 4'b0101;
        @(negedge clock);
        if (!hold_start) start = 1'b0;
        mul_a = rand64();
        mul_b = rand64();
        check("run_alu_sel", 64'(alu_sel), 64'(ADD_SEL));
        check("run_dp_stall", 64'(dp_stall), 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("run_cycles", 64'(n), 64'(exp_n));
        check("done_pulse", 64'(done), 64'd1);
        check("product", product, exp_p);
        check("ready_in_done", 64'(ready), 64'd0);
        @(negedge clock);
        check("done_cleared", 64'(done), 64'd0);
        check("ready_after_done", 64'(ready), 64'd1);
        check("product_held", product, exp_p);
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mul_a  = '0;
        mul_b  = '0;
        dp_a   = 64'd5;
        dp_b   = 64'd3;
        dp_sel = ADD_SEL;
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("pass_a", alu_a, 64'd5);
        check("pass_b", alu_b, 64'd3);
        check("pass_sel", 64'(alu_sel), 64'(ADD_SEL));
        reset = 1'b0;

        run_mul(64'd3, 64'd5, 1'b0);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        run_mul(64'd7, 64'd0, 1'b0);
        run_mul(64'd1, 64'h8000_0000_0000_0000, 1'b0);
        run_mul(64'd12345, 64'd678, 1'b1);

        // Random pass-through while idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            dp_a   = rand64();
            dp_b   = rand64();
            dp_sel = 4'($urandom_range(0, 15));
            #1;
            check("idle_pass_a", alu_a, dp_a);
            check("idle_pass_b", alu_b, dp_b);
            check("idle_pass_sel", 64'(alu_sel), 64'(dp_sel));
        end

        for (int i = 0; i < 20; i++) begin
            run_mul(rand64(), rand64() >> $urandom_range(0, 63), 1'($urandom_range(0, 1)));
        end

        // Reset during the 10th RUN cycle of a 64-cycle multiply.
        @(negedge clock);
        start = 1'b1;
        mul_a = 64'd9;
        mul_b = 64'h8000_0000_0000_0000;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("mid_run_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle", 64'(ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
